// File: rtl/imem_loader.sv
// Program loader: turns a length-prefixed, big-endian byte stream into consecutive
// instruction-memory word writes and keeps the CPU held in reset until the image is complete.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  InValid,
    input  logic [7:0]            InData,
    output logic                  InReady,
    output logic                  ImWe,
    output logic [ADDR_WIDTH-1:0] ImAddr,
    output logic [31:0]           ImWData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic [15:0]           WordCnt,
    output logic                  CpuHold
);

    // Largest word count that still fits between BASE_ADDR and the top of memory.
    localparam int unsigned LenMax = (1 << ADDR_WIDTH) - BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           asm_q, asm_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic                  hold_q, hold_d;

    logic                  xfer;
    logic [15:0]           len_full;
    logic [15:0]           word_cnt_inc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            asm_q      <= '0;
            byte_idx_q <= '0;
            addr_q     <= BaseAddr;
            wdata_q    <= '0;
            word_cnt_q <= '0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_cnt_q <= word_cnt_d;
            hold_q     <= hold_d;
        end
    end

    // Readiness is a pure state decode so it never depends on InValid.
    always_comb begin
        InReady = 1'b0;
        Busy    = 1'b0;
        unique case (state_q)
            StLenHi, StLenLo, StData: begin
                InReady = 1'b1;
                Busy    = 1'b1;
            end
            StWrite: Busy = 1'b1;
            default: ;
        endcase
    end

    assign xfer         = InValid && InReady;
    assign len_full     = {len_q[15:8], InData};
    assign word_cnt_inc = word_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        asm_d      = asm_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_cnt_d = word_cnt_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (Start) begin
                    state_d    = StLenHi;
                    word_cnt_d = '0;
                    addr_d     = BaseAddr;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = InData;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d[7:0] = InData;
                    byte_idx_d = '0;
                    if (len_full == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(len_full) > LenMax) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte completes the word; stage data and address for WRITE.
                        wdata_d    = {asm_q, InData};
                        addr_d     = BaseAddr + word_cnt_q[ADDR_WIDTH-1:0];
                        byte_idx_d = '0;
                        state_d    = StWrite;
                    end else begin
                        asm_d      = {asm_q[15:0], InData};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase
    end

    // CPU is released only while a completed image is in memory.
    assign hold_d = (state_d != StDone);

    assign ImWe    = (state_q == StWrite);
    assign ImAddr  = addr_q;
    assign ImWData = wdata_q;
    assign Done    = (state_q == StDone);
    assign Err     = (state_q == StError);
    assign WordCnt = word_cnt_q;
    assign CpuHold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table of complete loads plus hand-written
// sequences for asynchronous reset, Start during a load, restart, and the length limit.
module tb_imem_loader;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       sel;  // 0 drives the default instance, 1 the ADDR_WIDTH=4 instance

    logic        ready0, we0, busy0, done0, err0, hold0;
    logic [9:0]  addr0;
    logic [31:0] wdata0;
    logic [15:0] cnt0;

    logic        ready4, we4, busy4, done4, err4, hold4;
    logic [3:0]  addr4;
    logic [31:0] wdata4;
    logic [15:0] cnt4;

    imem_loader dut (
        .Clk(Clk), .Reset(Reset), .Start(start & ~sel), .InValid(in_valid & ~sel),
        .InData(in_data), .InReady(ready0), .ImWe(we0), .ImAddr(addr0), .ImWData(wdata0),
        .Busy(busy0), .Done(done0), .Err(err0), .WordCnt(cnt0), .CpuHold(hold0)
    );

    imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(start & sel), .InValid(in_valid & sel),
        .InData(in_data), .InReady(ready4), .ImWe(we4), .ImAddr(addr4), .ImWData(wdata4),
        .Busy(busy4), .Done(done4), .Err(err4), .WordCnt(cnt4), .CpuHold(hold4)
    );

    logic rdy, busy;
    assign rdy  = sel ? ready4 : ready0;
    assign busy = sel ? busy4 : busy0;

    // Memory model and write log, sampled mid-cycle.
    logic [31:0] mem [0:1023];
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr4_n;
    logic [3:0]  wr4_addr;
    logic [31:0] wr4_data;
    int          overlap;

    always @(negedge Clk) begin
        if (we0) begin
            mem[addr0] = wdata0;
            wr_addr.push_back(addr0);
            wr_data.push_back(wdata0);
        end
        if (we4) begin
            wr4_n++;
            wr4_addr = addr4;
            wr4_data = wdata4;
        end
        if ((we0 && ready0) || (we4 && ready4)) overlap++;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge Clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!rdy && k < 50) begin
            @(posedge Clk); #1;
            k++;
        end
        if (!rdy) begin
            check("ready_timeout", {31'd0, rdy}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic send_len(input logic [15:0] n, input bit gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(posedge Clk); #1;
            k++;
        end
        if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
    endtask

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          toggle;
        bit          exp_done;
        logic [15:0] exp_cnt;
        bit          exp_hold;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{16'd2, 32'h3c10ffff, 32'h0000000c, 1'b0, 1'b1, 16'd2, 1'b0};
        vecs[1] = '{16'd2, 32'h3c10ffff, 32'h0000000c, 1'b1, 1'b1, 16'd2, 1'b0};
        vecs[2] = '{16'd0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0, 1'b0};
        vecs[3] = '{16'd1, 32'hdeadbeef, 32'h0, 1'b1, 1'b1, 16'd1, 1'b0};

        start = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
        wr4_n = 0; overlap = 0; wr4_addr = '0; wr4_data = '0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_we", {31'd0, we0}, 32'd0);
        check("rst_addr", {22'd0, addr0}, 32'd0);
        check("rst_wdata", wdata0, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_cnt", {16'd0, cnt0}, 32'd0);
        check("rst_hold", {31'd0, hold0}, 32'd1);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        check("idle_not_ready", {31'd0, ready0}, 32'd0);

        // Table of complete loads on the default instance.
        for (int i = 0; i < 4; i++) begin
            wr_addr.delete();
            wr_data.delete();
            pulse_start();
            send_len(vecs[i].n, vecs[i].toggle);
            if (vecs[i].n >= 16'd1) send_word(vecs[i].w0, vecs[i].toggle);
            if (vecs[i].n >= 16'd2) send_word(vecs[i].w1, vecs[i].toggle);
            wait_idle();
            check($sformatf("v%0d_done", i), {31'd0, done0}, {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d_err", i), {31'd0, err0}, 32'd0);
            check($sformatf("v%0d_cnt", i), {16'd0, cnt0}, {16'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d_hold", i), {31'd0, hold0}, {31'd0, vecs[i].exp_hold});
            check($sformatf("v%0d_ready", i), {31'd0, ready0}, 32'd0);
            check($sformatf("v%0d_nwr", i), wr_addr.size(), {16'd0, vecs[i].n});
            for (int j = 0; j < wr_addr.size() && j < 2; j++) begin
                check($sformatf("v%0d_wa%0d", i, j), {22'd0, wr_addr[j]}, j);
                check($sformatf("v%0d_wd%0d", i, j), wr_data[j],
                      (j == 0) ? vecs[i].w0 : vecs[i].w1);
            end
        end

        // Asynchronous reset two bytes into word 3; earlier words must survive.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_len(16'd4, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h44, 1'b0);
        #2 Reset = 1'b0;
        #1;
        check("ar_ready", {31'd0, ready0}, 32'd0);
        check("ar_we", {31'd0, we0}, 32'd0);
        check("ar_addr", {22'd0, addr0}, 32'd0);
        check("ar_wdata", wdata0, 32'd0);
        check("ar_busy", {31'd0, busy0}, 32'd0);
        check("ar_done", {31'd0, done0}, 32'd0);
        check("ar_cnt", {16'd0, cnt0}, 32'd0);
        check("ar_hold", {31'd0, hold0}, 32'd1);
        check("ar_nwr", wr_addr.size(), 32'd3);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_len(16'd1, 1'b0);
        send_word(32'h5a5a5a5a, 1'b0);
        wait_idle();
        check("ar_reload_done", {31'd0, done0}, 32'd1);
        check("ar_reload_addr", (wr_addr.size() > 0) ? {22'd0, wr_addr[0]} : 32'hffffffff, 32'd0);
        check("ar_mem0", mem[0], 32'h5a5a5a5a);
        check("ar_mem1", mem[1], 32'h22222222);
        check("ar_mem2", mem[2], 32'h33333333);

        // Start during DATA is ignored.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_len(16'd2, 1'b0);
        send_byte(8'h3c, 1'b0);
        send_byte(8'h10, 1'b0);
        pulse_start();
        check("sd_busy", {31'd0, busy0}, 32'd1);
        send_byte(8'hff, 1'b0);
        send_byte(8'hff, 1'b0);
        send_word(32'h0000000c, 1'b0);
        wait_idle();
        check("sd_done", {31'd0, done0}, 32'd1);
        check("sd_cnt", {16'd0, cnt0}, 32'd2);
        check("sd_nwr", wr_addr.size(), 32'd2);
        check("sd_mem0", mem[0], 32'h3c10ffff);
        check("sd_mem1", mem[1], 32'h0000000c);

        // Start in DONE reasserts hold and reloads from the base address.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        check("rs_hold", {31'd0, hold0}, 32'd1);
        check("rs_done", {31'd0, done0}, 32'd0);
        check("rs_busy", {31'd0, busy0}, 32'd1);
        check("rs_cnt", {16'd0, cnt0}, 32'd0);
        send_len(16'd1, 1'b0);
        send_word(32'hcafef00d, 1'b0);
        wait_idle();
        check("rs_addr", (wr_addr.size() > 0) ? {22'd0, wr_addr[0]} : 32'hffffffff, 32'd0);
        check("rs_mem0", mem[0], 32'hcafef00d);
        check("rs_final_hold", {31'd0, hold0}, 32'd0);

        // Length limit on the 16-word instance: 16 fits, 17 is rejected.
        sel = 1'b1;
        pulse_start();
        send_len(16'd16, 1'b0);
        check("lim16_err", {31'd0, err4}, 32'd0);
        check("lim16_ready", {31'd0, ready4}, 32'd1);
        do_reset();
        pulse_start();
        send_len(16'd17, 1'b0);
        check("lim17_err", {31'd0, err4}, 32'd1);
        check("lim17_hold", {31'd0, hold4}, 32'd1);
        check("lim17_ready", {31'd0, ready4}, 32'd0);
        check("lim17_busy", {31'd0, busy4}, 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        check("lim17_nwr", wr4_n, 32'd0);
        pulse_start();
        check("er_restart_busy", {31'd0, busy4}, 32'd1);
        check("er_restart_err", {31'd0, err4}, 32'd0);
        send_len(16'd1, 1'b0);
        send_word(32'h01020304, 1'b0);
        wait_idle();
        check("er_reload_done", {31'd0, done4}, 32'd1);
        check("er_reload_cnt", {16'd0, cnt4}, 32'd1);
        check("er_reload_nwr", wr4_n, 32'd1);
        check("er_reload_addr", {28'd0, wr4_addr}, 32'd0);
        check("er_reload_data", wr4_data, 32'h01020304);
        check("er_reload_hold", {31'd0, hold4}, 32'd0);

        check("we_ready_overlap", overlap, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader, the write side of the instruction memory. The CPU core and the bench read program words from instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes them to consecutive instruction-memory word addresses.
- Holds the CPU in reset until the program is loaded, so the core boots from a complete image.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width (depth = 2^ADDR_WIDTH words)
BASE_ADDR, 0, first word address written

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
InValid  input  1  input byte valid
InData  input  8  input byte
InReady  output  1  loader can accept a byte
ImWe  output  1  instruction-memory write enable, one-cycle pulse per word
ImAddr  output  ADDR_WIDTH  instruction-memory word address
ImWData  output  32  instruction word to write
Busy  output  1  load in progress
Done  output  1  last load completed successfully
Err  output  1  last load rejected (length too large)
WordCnt  output  16  words written in current/last load
CpuHold  output  1  active-high hold; CPU reset is asserted while 1

Behaviour:
- Reset (Reset=0, asynchronous):
  - State IDLE.
  - InReady=0, ImWe=0, ImAddr=BASE_ADDR, ImWData=0, Busy=0, Done=0, Err=0, WordCnt=0, CpuHold=1.
  - Any partial word is discarded. Words already written stay in memory.
- Byte transfer: occurs at a rising edge with InValid=1 and InReady=1. InReady does not depend combinationally on InValid.
- Stream format:
  - 2-byte length N, MSB first.
  - Then 4*N data bytes, each word MSB first (first byte goes to ImWData[31:24]).
- States:
  - IDLE: InReady=0, Busy=0. Start=1 -> LEN_HI. On entry to LEN_HI: WordCnt=0, Done=0, Err=0, ImAddr=BASE_ADDR, CpuHold=1.
  - LEN_HI: InReady=1, Busy=1. On transfer, latch N[15:8] -> LEN_LO.
  - LEN_LO: InReady=1. On transfer, latch N[7:0] and go to one of:
    - N==0 -> DONE.
    - N > 2^ADDR_WIDTH - BASE_ADDR -> ERROR.
    - otherwise -> DATA with byte index 0.
  - DATA: InReady=1. Each transfer shifts the byte into a 32-bit assembly register. On the 4th byte -> WRITE.
  - WRITE: lasts exactly one cycle.
    - ImWe=1, ImWData=assembled word, ImAddr=BASE_ADDR+WordCnt, InReady=0.
    - At the end of the cycle, WordCnt increments.
    - If the new WordCnt==N -> DONE, else -> DATA.
  - DONE: Busy=0, Done=1, CpuHold=0, InReady=0.
  - ERROR: Busy=0, Err=1, CpuHold=1, InReady=0. No memory writes occur.
- ImAddr is registered and holds its last value outside WRITE. ImWData holds its last value. ImWe=0 in every state except WRITE.
- Throughput: at most one word per 5 cycles (4 transfer cycles + 1 write cycle).
- Start while Busy=1 is ignored. Start in DONE or ERROR restarts the load: CpuHold reasserts in the cycle after the Start pulse.
- InValid stalls in any receive state hold the state indefinitely. There is no timeout.
- Bytes presented while InReady=0 are not consumed. The source must keep them held.
- WordCnt is 16 bits and cannot wrap, because N ≤ 2^ADDR_WIDTH ≤ 65536 is enforced by the ERROR check (requires ADDR_WIDTH ≤ 16).

Test Plan:
- Reset asserted mid-DATA after 2 bytes of word 3 -> all outputs at reset values immediately (asynchronous). After release, Start plus a new stream loads from BASE_ADDR. Words 0-2 remain in memory.
- Start, stream 00 02 3C 10 FF FF 00 00 00 0C -> two ImWe pulses: addr 0 data 3c10ffff, addr 1 data 0000000c. Then Done=1, WordCnt=2, CpuHold=0.
- Same stream with InValid toggling 1/0 each cycle -> identical writes and final state. ImWe never coincides with InReady=1.
- Stream 00 00 -> DONE with zero ImWe pulses, WordCnt=0, CpuHold=0.
- ADDR_WIDTH=4, BASE_ADDR=0, length 00 11 (17) -> ERROR: Err=1, CpuHold=1, InReady=0, no ImWe pulse. A following Start restarts a load.
- Start pulsed during DATA -> ignored, and the load completes normally. Start in DONE -> CpuHold=1 again, and the second load overwrites from BASE_ADDR.
